// File: rtl/oam_dma_controller_pkg.sv
// Shared constants, FSM state type and source-page helper for the OAM DMA block.
package oam_dma_controller_pkg;

  localparam int          DMA_LENGTH   = 160;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [7:0]  LAST_INDEX   = 8'(DMA_LENGTH - 1);

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_START = 2'd1,
    DMA_READ  = 2'd2,
    DMA_WRITE = 2'd3
  } dma_state_t;

  // Echo RAM pages E0..FF alias work RAM, so the source page folds down by clearing bit 5.
  function automatic logic [7:0] echoToWram(input logic [7:0] page);
    return (page >= 8'hE0) ? (page & 8'hDF) : page;
  endfunction

endpackage

// File: rtl/oam_dma_controller_if.sv
// Bus bundle between the OAM DMA sequencer and its surroundings (CPU, mmu read path, OAM).
interface oam_dma_controller_if;

  logic        iCpuWe;
  logic [15:0] iCpuAddr;
  logic [7:0]  iCpuData;
  logic [7:0]  iMemData;
  logic        oDmaActive;
  logic        oDmaReadRequest;
  logic [15:0] oDmaAddr;
  logic        oOamWe;
  logic [7:0]  oOamAddr;
  logic [7:0]  oOamData;
  logic [7:0]  oDmaReg;

  modport master (
    input  iCpuWe, iCpuAddr, iCpuData, iMemData,
    output oDmaActive, oDmaReadRequest, oDmaAddr, oOamWe, oOamAddr, oOamData, oDmaReg
  );

  modport slave (
    output iCpuWe, iCpuAddr, iCpuData, iMemData,
    input  oDmaActive, oDmaReadRequest, oDmaAddr, oOamWe, oOamAddr, oOamData, oDmaReg
  );

endinterface

// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: a write to FF46 copies one 160-byte page into OAM, one read and
// one write cycle per byte, after a single bus-handover bubble.
module oam_dma_controller
  import oam_dma_controller_pkg::*;
(
  input logic                  iClock,
  input logic                  iReset,
  oam_dma_controller_if.master bus
);

  dma_state_t rState;
  dma_state_t wNextState;
  logic [7:0] rIndex;
  logic [7:0] rSrcHigh;
  logic [7:0] rDmaReg;
  logic       wTrigger;
  logic       wActive;
  logic       wReadRequest;
  logic       wOamWe;
  logic [7:0] wOamAddr;
  logic [7:0] wOamData;

  assign wTrigger = bus.iCpuWe && (bus.iCpuAddr == DMA_REG_ADDR);

  // State, byte index, source page and FF46 readback; a trigger always restarts from the bubble.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      rState   <= DMA_IDLE;
      rIndex   <= 8'd0;
      rSrcHigh <= 8'd0;
      rDmaReg  <= 8'hFF;
    end else begin
      rState <= wNextState;
      if (wTrigger) begin
        rDmaReg  <= bus.iCpuData;
        rSrcHigh <= echoToWram(bus.iCpuData);
      end
      if (rState == DMA_START) begin
        rIndex <= 8'd0;
      end else if ((rState == DMA_WRITE) && !wTrigger && (rIndex != LAST_INDEX)) begin
        rIndex <= rIndex + 8'd1;
      end
    end
  end

  // Next-state selection and per-state strobe decode.
  always_comb begin
    wNextState   = rState;
    wActive      = 1'b0;
    wReadRequest = 1'b0;
    wOamWe       = 1'b0;
    wOamAddr     = 8'd0;
    wOamData     = 8'd0;
    unique case (rState)
      DMA_IDLE: begin
        wNextState = DMA_IDLE;
      end
      DMA_START: begin
        wActive    = 1'b1;
        wNextState = DMA_READ;
      end
      DMA_READ: begin
        wActive      = 1'b1;
        wReadRequest = 1'b1;
        wNextState   = DMA_WRITE;
      end
      DMA_WRITE: begin
        wActive    = 1'b1;
        wOamWe     = 1'b1;
        wOamAddr   = rIndex;
        wOamData   = bus.iMemData;
        wNextState = (rIndex == LAST_INDEX) ? DMA_IDLE : DMA_READ;
      end
    endcase
    if (wTrigger) begin
      wNextState = DMA_START;
    end
  end

  assign bus.oDmaActive      = wActive;
  assign bus.oDmaReadRequest = wReadRequest;
  assign bus.oDmaAddr        = {rSrcHigh, rIndex};
  assign bus.oOamWe          = wOamWe;
  assign bus.oOamAddr        = wOamAddr;
  assign bus.oOamData        = wOamData;
  assign bus.oDmaReg         = rDmaReg;

endmodule
